// File: rtl/msg_encrypt_pad.sv
// msg_encrypt_pad: frames a DM string into a space-padded 64-byte block, LFSR-encrypts it with even parity and writes DM[64..127]
module msg_encrypt_pad #(
  parameter int BLK_LEN  = 64,
  parameter int MAX_STR  = 52,
  parameter int OUT_BASE = 64
) (
  input  logic       clk,
  input  logic       init,
  input  logic       req,
  output logic       ack,
  input  logic [3:0] pre_length,
  input  logic [6:0] lfsr_ptrn,
  input  logic [6:0] lfsr_init,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);
  localparam int IW = $clog2(BLK_LEN);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state;
  logic armed, ph;
  logic [3:0] pl;
  logic [6:0] ptrn, lfsr, c;
  logic [IW-1:0] i;
  logic [7:0] ci, ni;
  logic msg, msg_n;
  always_comb begin
    ci = 8'(i);
    ni = ci + 8'd1;
    msg = ci >= 8'(pl) && ci < 8'(pl) + 8'(MAX_STR);
    msg_n = ni >= 8'(pl) && ni < 8'(pl) + 8'(MAX_STR);
    c = lfsr ^ (msg ? 7'(rd_data - 8'h20) : 7'h00);
    wr_data = wr_en ? {^c, c} : 8'h00;
  end
  // each index spends one RD cycle (ph=0) and one WR cycle (ph=1); strobes are set on the edge entering their phase
  always_ff @(posedge clk or posedge init)
    if (init) begin
      state <= IDLE;
      armed <= 1'b0;
      ph <= 1'b0;
      pl <= 4'd0;
      ptrn <= 7'h00;
      lfsr <= 7'h00;
      i <= '0;
      ack <= 1'b0;
      rd_en <= 1'b0;
      rd_addr <= 8'h00;
      wr_en <= 1'b0;
      wr_addr <= 8'h00;
    end else begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        IDLE:
          if (req) armed <= 1'b1;
          else if (armed) begin
            armed <= 1'b0;
            state <= LOAD;
          end
        LOAD: begin
          pl <= pre_length < 4'd10 ? 4'd10 : pre_length;
          ptrn <= lfsr_ptrn;
          lfsr <= lfsr_init == 7'h00 ? 7'h01 : lfsr_init;
          i <= '0;
          ph <= 1'b0;
          state <= RUN;
        end
        RUN:
          if (!ph) begin
            ph <= 1'b1;
            wr_en <= 1'b1;
            wr_addr <= 8'(OUT_BASE) + ci;
          end else begin
            ph <= 1'b0;
            lfsr <= {lfsr[5:0], ^(lfsr & ptrn)};
            i <= i + 1'b1;
            if (i == IW'(BLK_LEN - 1)) state <= DONE;
            else if (msg_n) begin
              rd_en <= 1'b1;
              rd_addr <= ni - 8'(pl);
            end
          end
        DONE:
          if (req) begin
            state <= IDLE;
            armed <= 1'b1;
            ack <= 1'b0;
          end else ack <= 1'b1;
      endcase
    end
endmodule

// File: tb/tb_msg_encrypt_pad.sv
// tb_msg_encrypt_pad: directed bench with a data-memory model and a golden encryptor
module tb_msg_encrypt_pad;
  logic clk = 1'b0;
  logic init = 1'b1;
  logic req = 1'b0;
  logic ack, rd_en, wr_en;
  logic [3:0] pre_length = 4'd10;
  logic [6:0] lfsr_ptrn = 7'h60;
  logic [6:0] lfsr_init = 7'h01;
  logic [7:0] rd_addr, rd_data, wr_addr, wr_data;
  logic [7:0] mem [0:255];
  logic [7:0] rd_q = 8'h00;
  logic bd_en = 1'b0;
  logic [7:0] bd_addr = 8'h00;
  logic [7:0] bd_data = 8'h00;
  logic [7:0] exp_b [0:63];
  logic [7:0] rlog [0:4095];
  logic [7:0] wlog [0:4095];
  logic [7:0] base_ref [0:6] = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0, 8'h41};
  logic [6:0] taps [0:8] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
  int nrd = 0, nwr = 0, both = 0;
  int cmp = 0, bad = 0;

  msg_encrypt_pad dut (
    .clk(clk), .init(init), .req(req), .ack(ack),
    .pre_length(pre_length), .lfsr_ptrn(lfsr_ptrn), .lfsr_init(lfsr_init),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;
  assign rd_data = rd_q;

  always @(posedge clk) begin
    if (rd_en) rd_q <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
    else if (bd_en) mem[bd_addr] <= bd_data;
    if (rd_en) begin
      rlog[nrd[11:0]] = rd_addr;
      nrd = nrd + 1;
    end
    if (wr_en) begin
      wlog[nwr[11:0]] = wr_addr;
      nwr = nwr + 1;
    end
    if (rd_en && wr_en) both = both + 1;
  end

  function automatic void golden(input logic [3:0] p_in, input logic [6:0] t, input logic [6:0] s);
    int p;
    logic [6:0] l, pt, c;
    p = p_in < 4'd10 ? 10 : int'(p_in);
    l = s == 7'h00 ? 7'h01 : s;
    for (int k = 0; k < 64; k++) begin
      pt = (k >= p && k < p + 52) ? 7'(mem[k - p] - 8'h20) : 7'h00;
      c = pt ^ l;
      exp_b[k] = {^c, c};
      l = {l[5:0], ^(l & t)};
    end
  endfunction

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_en = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  task automatic set_msg(input string s);
    for (int k = 0; k < 52; k++) poke(8'(k), k < s.len() ? 8'(s[k]) : 8'h20);
  endtask

  task automatic fill_out(input logic [7:0] v);
    for (int k = 64; k < 128; k++) poke(8'(k), v);
  endtask

  task automatic start_run(input logic [3:0] p, input logic [6:0] t, input logic [6:0] s);
    @(negedge clk);
    pre_length = p;
    lfsr_ptrn = t;
    lfsr_init = s;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!ack && n < 300);
  endtask

  task automatic test_reset;
    #1;
    cmp++;
    if ({ack, rd_en, rd_addr, wr_en, wr_addr, wr_data} !== 19'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 0", {ack, rd_en, rd_addr, wr_en, wr_addr, wr_data});
    end
    @(negedge clk);
    init = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    cmp++;
    if (nrd !== 0 || nwr !== 0 || ack !== 1'b0) begin
      bad++;
      $display("FAIL idle_quiet: reads %0d writes %0d ack %b required 0 0 0", nrd, nwr, ack);
    end
  endtask

  task automatic test_base;
    int n, w0;
    set_msg("Mr.");
    fill_out(8'hEE);
    w0 = nwr;
    start_run(4'd10, 7'h60, 7'h01);
    wait_ack(n);
    cmp++;
    if (n !== 130) begin
      bad++;
      $display("FAIL base_latency: got %0d required 130", n);
    end
    for (int k = 0; k < 7; k++) begin
      cmp++;
      if (mem[64 + k] !== base_ref[k]) begin
        bad++;
        $display("FAIL base_byte%0d: got %h required %h", 64 + k, mem[64 + k], base_ref[k]);
      end
    end
    cmp++;
    if (mem[74] !== 8'h35) begin
      bad++;
      $display("FAIL base_M: got %h required 35", mem[74]);
    end
    cmp++;
    if (nwr - w0 !== 64) begin
      bad++;
      $display("FAIL base_writes: got %0d required 64", nwr - w0);
    end
    golden(4'd10, 7'h60, 7'h01);
    for (int k = 0; k < 64; k++) begin
      cmp++;
      if (mem[64 + k] !== exp_b[k]) begin
        bad++;
        $display("FAIL base_image byte %0d: got %h required %h", 64 + k, mem[64 + k], exp_b[k]);
      end
    end
  endtask

  task automatic test_degenerate;
    int n;
    fill_out(8'hEE);
    start_run(4'd3, 7'h60, 7'h00);
    wait_ack(n);
    cmp++;
    if (n !== 130 || mem[64] !== 8'h81 || mem[74] !== 8'h35) begin
      bad++;
      $display("FAIL degenerate_hand: latency %0d b64 %h b74 %h required 130 81 35", n, mem[64], mem[74]);
    end
    golden(4'd10, 7'h60, 7'h01);
    for (int k = 0; k < 64; k++) begin
      cmp++;
      if (mem[64 + k] !== exp_b[k]) begin
        bad++;
        $display("FAIL degenerate_image byte %0d: got %h required %h", 64 + k, mem[64 + k], exp_b[k]);
      end
    end
  endtask

  task automatic test_sweep;
    int n;
    logic [6:0] s;
    logic [3:0] p;
    set_msg("Hello, World! 0123 ~xyz");
    for (int t = 0; t < 9; t++) begin
      s = 7'($urandom_range(127, 1));
      p = 4'(10 + t % 6);
      fill_out(8'hEE);
      golden(p, taps[t], s);
      start_run(p, taps[t], s);
      wait_ack(n);
      cmp++;
      if (n !== 130) begin
        bad++;
        $display("FAIL sweep%0d_latency: got %0d required 130", t, n);
      end
      for (int k = 0; k < 64; k++) begin
        cmp++;
        if (mem[64 + k] !== exp_b[k]) begin
          bad++;
          $display("FAIL sweep%0d byte %0d: got %h required %h (ptrn %h seed %h pl %0d)", t, 64 + k, mem[64 + k], exp_b[k], taps[t], s, p);
        end
      end
    end
  endtask

  task automatic test_full_string;
    int n, r0, w0;
    set_msg("ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz");
    fill_out(8'hEE);
    golden(4'd15, 7'h48, 7'h2B);
    r0 = nrd;
    w0 = nwr;
    start_run(4'd15, 7'h48, 7'h2B);
    wait_ack(n);
    cmp++;
    if (nrd - r0 !== 49) begin
      bad++;
      $display("FAIL full_reads: got %0d required 49", nrd - r0);
    end
    for (int k = 0; k < 49; k++) begin
      cmp++;
      if (rlog[12'(r0 + k)] !== 8'(k)) begin
        bad++;
        $display("FAIL full_read_order %0d: got %0d required %0d", k, rlog[12'(r0 + k)], k);
      end
    end
    for (int k = 0; k < 64; k++) begin
      cmp++;
      if (wlog[12'(w0 + k)] !== 8'(64 + k)) begin
        bad++;
        $display("FAIL full_write_order %0d: got %0d required %0d", k, wlog[12'(w0 + k)], 64 + k);
      end
    end
    for (int k = 0; k < 64; k++) begin
      cmp++;
      if (mem[64 + k] !== exp_b[k]) begin
        bad++;
        $display("FAIL full_image byte %0d: got %h required %h", 64 + k, mem[64 + k], exp_b[k]);
      end
    end
  endtask

  task automatic test_mid_reset;
    int n, w0, e;
    fill_out(8'hEE);
    w0 = nwr;
    start_run(4'd10, 7'h60, 7'h01);
    repeat (41) @(posedge clk);
    #1 init = 1'b1;
    #1;
    cmp++;
    if ({ack, rd_en, rd_addr, wr_en, wr_addr, wr_data} !== 19'h0) begin
      bad++;
      $display("FAIL midreset_outputs: got %h required 0", {ack, rd_en, rd_addr, wr_en, wr_addr, wr_data});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    cmp++;
    if (nwr - w0 !== 20 || ack !== 1'b0) begin
      bad++;
      $display("FAIL midreset_writes: writes %0d ack %b required 20 0", nwr - w0, ack);
    end
    e = 0;
    for (int k = 84; k < 128; k++) if (mem[k] !== 8'hEE) e++;
    cmp++;
    if (e !== 0) begin
      bad++;
      $display("FAIL midreset_untouched: got %0d altered bytes required 0", e);
    end
    golden(4'd10, 7'h60, 7'h01);
    start_run(4'd10, 7'h60, 7'h01);
    wait_ack(n);
    cmp++;
    if (n !== 130) begin
      bad++;
      $display("FAIL midreset_rerun_latency: got %0d required 130", n);
    end
    for (int k = 0; k < 64; k++) begin
      cmp++;
      if (mem[64 + k] !== exp_b[k]) begin
        bad++;
        $display("FAIL midreset_rerun byte %0d: got %h required %h", 64 + k, mem[64 + k], exp_b[k]);
      end
    end
  endtask

  task automatic test_req_hold;
    int n, r0, w0;
    @(negedge clk);
    pre_length = 4'd12;
    lfsr_ptrn = 7'h5C;
    lfsr_init = 7'h33;
    req = 1'b1;
    r0 = nrd;
    w0 = nwr;
    @(posedge clk);
    #1;
    cmp++;
    if (ack !== 1'b0) begin
      bad++;
      $display("FAIL done_ack_drop: got %b required 0", ack);
    end
    repeat (19) @(posedge clk);
    #1;
    cmp++;
    if (nrd !== r0 || nwr !== w0 || ack !== 1'b0) begin
      bad++;
      $display("FAIL req_hold: reads %0d writes %0d ack %b required 0 0 0", nrd - r0, nwr - w0, ack);
    end
    fill_out(8'hEE);
    golden(4'd12, 7'h5C, 7'h33);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      req = (n >= 10 && n < 100) ? n[2] : 1'b0;
      @(posedge clk);
      n++;
      #1;
    end while (!ack && n < 300);
    cmp++;
    if (n !== 130) begin
      bad++;
      $display("FAIL req_toggle_latency: got %0d required 130", n);
    end
    for (int k = 0; k < 64; k++) begin
      cmp++;
      if (mem[64 + k] !== exp_b[k]) begin
        bad++;
        $display("FAIL req_toggle byte %0d: got %h required %h", 64 + k, mem[64 + k], exp_b[k]);
      end
    end
    fill_out(8'hEE);
    start_run(4'd12, 7'h5C, 7'h33);
    wait_ack(n);
    cmp++;
    if (n !== 130) begin
      bad++;
      $display("FAIL second_run_latency: got %0d required 130", n);
    end
    for (int k = 0; k < 64; k++) begin
      cmp++;
      if (mem[64 + k] !== exp_b[k]) begin
        bad++;
        $display("FAIL second_run byte %0d: got %h required %h", 64 + k, mem[64 + k], exp_b[k]);
      end
    end
    cmp++;
    if (both !== 0) begin
      bad++;
      $display("FAIL strobe_overlap: got %0d cycles required 0", both);
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 8'h20;
    test_reset;
    test_base;
    test_degenerate;
    test_sweep;
    test_full_string;
    test_mid_reset;
    test_req_hold;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
